// File: rtl/register_file_mp.sv
// ============================================================================
//  Module      : register_file_mp
//  Description : Parametrised multi-port register file. NUM_WR byte-enabled
//                write ports and NUM_RD registered read ports with valid
//                flags. Optional write-to-read bypass, optional hardwired-zero
//                entry 0, and a post-reset clear that runs either in the
//                reset cycle (parallel) or one entry per cycle (sequential).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1              clock, rising edge
//    rst_n      in   1              synchronous active-low reset
//    wr_en      in   NUM_WR         per-port write strobe
//    wr_addr    in   NUM_WR*AW      packed write addresses, port p = [p*AW +: AW]
//    wr_data    in   NUM_WR*WL      packed write data
//    wr_be      in   NUM_WR*WL/8    byte enables, bit b of port p enables byte b
//    rd_en      in   NUM_RD         per-port read strobe
//    rd_addr    in   NUM_RD*AW      packed read addresses
//    rd_data    out  NUM_RD*WL      registered read data
//    rd_valid   out  NUM_RD         rd_data of that port updated this cycle
//    init_done  out  1              storage cleared, ports are live
// ============================================================================
`default_nettype none

module register_file_mp #(
  parameter  int WORD_LENGTH = 32,
  parameter  int REG_AMOUNT  = 32,
  parameter  int NUM_WR      = 2,
  parameter  int NUM_RD      = 3,
  parameter  int BYPASS      = 1,
  parameter  int ZERO_REG    = 0,
  parameter  int SEQ_CLEAR   = 0,
  localparam int AW          = $clog2(REG_AMOUNT),
  localparam int NB          = WORD_LENGTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR*AW-1:0]          wr_addr,
  input  logic [NUM_WR*WORD_LENGTH-1:0] wr_data,
  input  logic [NUM_WR*NB-1:0]          wr_be,
  input  logic [NUM_RD-1:0]             rd_en,
  input  logic [NUM_RD*AW-1:0]          rd_addr,
  output logic [NUM_RD*WORD_LENGTH-1:0] rd_data,
  output logic [NUM_RD-1:0]             rd_valid,
  output logic                          init_done
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (WORD_LENGTH % 8 != 0) begin : g_bad_wl
      $error("register_file_mp: WORD_LENGTH must be a multiple of 8");
    end
    if (REG_AMOUNT < 2) begin : g_bad_depth
      $error("register_file_mp: REG_AMOUNT must be at least 2");
    end
    if (NUM_WR < 1 || NUM_WR > 4) begin : g_bad_nwr
      $error("register_file_mp: NUM_WR must be in 1..4");
    end
    if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_nrd
      $error("register_file_mp: NUM_RD must be in 1..8");
    end
  endgenerate

  // Clear FSM encoding (only exercised when SEQ_CLEAR != 0)
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WORD_LENGTH-1:0]        r_mem [REG_AMOUNT];
  logic [0:0]                    r_state;
  logic [AW-1:0]                 r_ptr;
  logic                          r_init_done;
  logic [NUM_RD*WORD_LENGTH-1:0] r_rd_data;
  logic [NUM_RD-1:0]             r_rd_valid;

  // Unpacked views of the port buses
  logic [AW-1:0]          w_wa    [NUM_WR];
  logic [WORD_LENGTH-1:0] w_wd    [NUM_WR];
  logic [NB-1:0]          w_wbe   [NUM_WR];
  logic [NUM_WR-1:0]      w_wr_ok;
  logic [AW-1:0]          w_ra    [NUM_RD];
  logic [WORD_LENGTH-1:0] w_rword [NUM_RD];

  // --------------------------------------------------------------------------
  // Write qualification: a write only takes effect once the file is live, the
  // address lies inside the array, and it does not target a hardwired zero.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      w_wa[p]    = wr_addr[p*AW +: AW];
      w_wd[p]    = wr_data[p*WORD_LENGTH +: WORD_LENGTH];
      w_wbe[p]   = wr_be[p*NB +: NB];
      w_wr_ok[p] = wr_en[p] && rst_n && r_init_done
                   && (int'(w_wa[p]) < REG_AMOUNT)
                   && !((ZERO_REG != 0) && (w_wa[p] == '0));
    end
  end

  // --------------------------------------------------------------------------
  // Init / clear control
  // --------------------------------------------------------------------------
  generate
    if (SEQ_CLEAR != 0) begin : g_seq_clear
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state     <= S_CLEAR;
          r_ptr       <= '0;
          r_init_done <= 1'b0;
        end else begin
          case (r_state)
            S_CLEAR: begin
              r_ptr <= r_ptr + AW'(1);
              // Leave CLEAR on the same edge that zeroes the last entry
              if (int'(r_ptr) == REG_AMOUNT - 1) begin
                r_state     <= S_READY;
                r_init_done <= 1'b1;
              end
            end
            S_READY: begin
              r_state <= S_READY;
            end
            default: begin
              r_state <= S_CLEAR;
            end
          endcase
        end
      end
    end else begin : g_par_clear
      // Storage is cleared in the reset cycle, so the file is live on the
      // first edge after release.
      always_ff @(posedge clk) begin
        r_state     <= S_READY;
        r_ptr       <= '0;
        r_init_done <= rst_n;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage. Ports are applied in ascending order so that, per byte, the
  // highest-index enabled port lands last and wins a same-address conflict.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((SEQ_CLEAR == 0) && !rst_n) begin
      for (int e = 0; e < REG_AMOUNT; e++) begin
        r_mem[e] <= '0;
      end
    end else if ((SEQ_CLEAR != 0) && rst_n && (r_state == S_CLEAR)) begin
      r_mem[r_ptr] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wr_ok[p] && w_wbe[p][b]) begin
            r_mem[w_wa[p]][b*8 +: 8] <= w_wd[p][b*8 +: 8];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read word selection. Out-of-range and hardwired-zero addresses read 0.
  // With bypass the same-cycle winning write bytes are merged over storage;
  // w_wr_ok already excludes the zero entry, so bypass never touches it.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      w_ra[r]    = rd_addr[r*AW +: AW];
      w_rword[r] = '0;
      if ((int'(w_ra[r]) < REG_AMOUNT) && !((ZERO_REG != 0) && (w_ra[r] == '0))) begin
        w_rword[r] = r_mem[w_ra[r]];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WR; p++) begin
            for (int b = 0; b < NB; b++) begin
              if (w_wr_ok[p] && w_wbe[p][b] && (w_wa[p] == w_ra[r])) begin
                w_rword[r][b*8 +: 8] = w_wd[p][b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered read ports. rd_data holds when a port is idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int r = 0; r < NUM_RD; r++) begin
        r_rd_valid[r] <= rd_en[r] && r_init_done;
        if (rd_en[r] && r_init_done) begin
          r_rd_data[r*WORD_LENGTH +: WORD_LENGTH] <= w_rword[r];
        end
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign init_done = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// ============================================================================
//  Module      : tb_register_file_mp
//  Description : Self-checking bench for register_file_mp. Two instances share
//                one stimulus stream:
//                  A: 32 entries, sequential clear, write-first bypass
//                  B: 24 entries, parallel clear, read-first, zero register
//                Expected read results are pushed to per-instance queues when
//                a read is driven and popped when the registered result shows.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic [2:0]  rd_en;
  logic [14:0] rd_addr;

  logic [95:0] rd_data_a, rd_data_b;
  logic [2:0]  rd_valid_a, rd_valid_b;
  logic        init_done_a, init_done_b;

  register_file_mp #(
    .WORD_LENGTH(32), .REG_AMOUNT(32), .NUM_WR(2), .NUM_RD(3),
    .BYPASS(1), .ZERO_REG(0), .SEQ_CLEAR(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_done(init_done_a)
  );

  register_file_mp #(
    .WORD_LENGTH(32), .REG_AMOUNT(24), .NUM_WR(2), .NUM_RD(3),
    .BYPASS(0), .ZERO_REG(1), .SEQ_CLEAR(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_done(init_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference state
  // --------------------------------------------------------------------------
  logic [31:0] m_a [32];
  logic [31:0] m_b [24];
  bit          a_live, b_live;
  int          a_cnt;
  logic [32:0] q_a [$];
  logic [32:0] q_b [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction

  // A: write-first, so same-cycle writes (port order = priority) show through
  function automatic logic [31:0] read_a(input logic [4:0] addr);
    logic [31:0] w;
    w = m_a[addr];
    if (rst_n && a_live)
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*5 +: 5] == addr)
          w = merge(w, wr_data[p*32 +: 32], wr_be[p*4 +: 4]);
    return w;
  endfunction

  // B: read-first, entry 0 hardwired to zero, addresses 24..31 read as zero
  function automatic logic [31:0] read_b(input logic [4:0] addr);
    if (addr == 5'd0 || addr >= 5'd24) return 32'h0;
    return m_b[addr];
  endfunction

  task automatic step();
    logic [32:0] e;
    logic [4:0]  ra, wa;
    for (int r = 0; r < 3; r++) begin
      ra = rd_addr[r*5 +: 5];
      q_a.push_back({rst_n && a_live && rd_en[r], read_a(ra)});
      q_b.push_back({rst_n && b_live && rd_en[r], read_b(ra)});
    end
    if (!rst_n) begin
      a_live = 1'b0;
      a_cnt  = 0;
      b_live = 1'b0;
      for (int i = 0; i < 24; i++) m_b[i] = 32'h0;
    end else begin
      if (!a_live) begin
        m_a[a_cnt] = 32'h0;
        a_cnt++;
        if (a_cnt == 32) a_live = 1'b1;
      end else begin
        for (int p = 0; p < 2; p++) begin
          wa = wr_addr[p*5 +: 5];
          if (wr_en[p]) m_a[wa] = merge(m_a[wa], wr_data[p*32 +: 32], wr_be[p*4 +: 4]);
        end
      end
      if (!b_live) begin
        b_live = 1'b1;
      end else begin
        for (int p = 0; p < 2; p++) begin
          wa = wr_addr[p*5 +: 5];
          if (wr_en[p] && wa != 5'd0 && wa < 5'd24)
            m_b[wa] = merge(m_b[wa], wr_data[p*32 +: 32], wr_be[p*4 +: 4]);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      e = q_a.pop_front();
      chk("rd_valid_a", {31'h0, rd_valid_a[r]}, {31'h0, e[32]});
      if (e[32]) chk("rd_data_a", rd_data_a[r*32 +: 32], e[31:0]);
      e = q_b.pop_front();
      chk("rd_valid_b", {31'h0, rd_valid_b[r]}, {31'h0, e[32]});
      if (e[32]) chk("rd_data_b", rd_data_b[r*32 +: 32], e[31:0]);
    end
    chk("init_done_a", {31'h0, init_done_a}, {31'h0, a_live});
    chk("init_done_b", {31'h0, init_done_b}, {31'h0, b_live});
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en[p]           = 1'b1;
    wr_addr[p*5 +: 5]  = a;
    wr_data[p*32 +: 32] = d;
    wr_be[p*4 +: 4]    = be;
  endtask

  task automatic set_rd(input int r, input logic [4:0] a);
    rd_en[r]          = 1'b1;
    rd_addr[r*5 +: 5] = a;
  endtask

  initial begin
    a_live = 1'b0; b_live = 1'b0; a_cnt = 0;
    rst_n = 1'b0;
    idle();
    step();
    step();
    chk("rst_rd_data_a", rd_data_a[31:0], 32'h0);
    chk("rst_rd_data_b", rd_data_b[95:64], 32'h0);
    chk("rst_rd_valid_a", {29'h0, rd_valid_a}, 32'h0);
    chk("rst_init_done_a", {31'h0, init_done_a}, 32'h0);

    // Abort a sequential clear at ptr=10 and restart it
    rst_n = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_done_a", {31'h0, init_done_a}, 32'h0);
    rst_n = 1'b1;

    // Full clear with writes and reads outstanding the whole time
    set_wr(0, 5'd5, 32'hDEADBEEF, 4'hF);
    set_rd(0, 5'd5); set_rd(1, 5'd9); set_rd(2, 5'd31);
    repeat (31) step();
    chk("clr31_done_a", {31'h0, init_done_a}, 32'h0);
    chk("clr31_valid_a", {29'h0, rd_valid_a}, 32'h0);
    step();
    chk("clr32_done_a", {31'h0, init_done_a}, 32'h1);
    idle();

    // Every entry of A reads zero after the clear
    for (int k = 0; k < 33; k += 3) begin
      for (int r = 0; r < 3; r++) set_rd(r, 5'((k + r) % 32));
      step();
    end
    idle();
    set_rd(0, 5'd5);
    step();
    chk("clr_drop_a", rd_data_a[31:0], 32'h0);
    idle();

    // Byte-enable merge over stored word
    set_wr(0, 5'd5, 32'h11223344, 4'hF); step();
    set_wr(0, 5'd5, 32'hAABBCCDD, 4'h5); step();
    idle(); set_rd(0, 5'd5); step();
    chk("be_merge_a", rd_data_a[31:0], 32'h11BB33DD);
    chk("be_merge_b", rd_data_b[31:0], 32'h11BB33DD);
    idle();

    // Same-address conflict, highest port wins per byte
    set_wr(0, 5'd7, 32'h11111111, 4'hF);
    set_wr(1, 5'd7, 32'h22222222, 4'h3);
    step();
    idle(); set_rd(1, 5'd7); step();
    chk("conflict_a", rd_data_a[63:32], 32'h11112222);
    chk("conflict_b", rd_data_b[63:32], 32'h11112222);
    idle();

    // Bypass (A) vs read-first (B)
    set_wr(0, 5'd3, 32'h01020304, 4'hF); step();
    set_wr(0, 5'd3, 32'hCAFEF00D, 4'hF); set_rd(0, 5'd3); step();
    chk("bypass_a", rd_data_a[31:0], 32'hCAFEF00D);
    chk("nobypass_b", rd_data_b[31:0], 32'h01020304);
    idle(); step();
    chk("hold_data_a", rd_data_a[31:0], 32'hCAFEF00D);
    chk("hold_valid_a", {31'h0, rd_valid_a[0]}, 32'h0);

    // Hardwired zero register on B
    set_wr(0, 5'd0, 32'hFFFFFFFF, 4'hF); step();
    idle();
    for (int r = 0; r < 3; r++) set_rd(r, 5'd0);
    step();
    for (int r = 0; r < 3; r++) chk("zero_reg_b", rd_data_b[r*32 +: 32], 32'h0);
    chk("zero_reg_vld_b", {29'h0, rd_valid_b}, 32'h7);
    chk("zero_reg_a", rd_data_a[31:0], 32'hFFFFFFFF);
    idle();

    // Out-of-range address on B (24-entry array)
    set_wr(1, 5'd30, 32'h5A5A5A5A, 4'hF); step();
    idle(); set_rd(2, 5'd30); step();
    chk("oor_b", rd_data_b[95:64], 32'h0);
    chk("oor_vld_b", {31'h0, rd_valid_b[2]}, 32'h1);
    chk("oor_a", rd_data_a[95:64], 32'h5A5A5A5A);
    idle();

    // Random traffic, narrow address window half the time to force conflicts
    for (int i = 0; i < 300; i++) begin
      wr_en   = 2'($urandom);
      wr_data = {$urandom, $urandom};
      wr_be   = 8'($urandom);
      rd_en   = 3'($urandom);
      for (int p = 0; p < 2; p++)
        wr_addr[p*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      for (int r = 0; r < 3; r++)
        rd_addr[r*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
